pwr_seq: RTL and testbench
==========================

PWR_SEQ -- requirements
Module: pwr_seq

Interface
REQ-001 SHALL have parameter PSCR_ADDR, default 7'h0E, SFR address of the power sequencer control register (PSCR).
REQ-002 SHALL have parameter DRAIN, default 2, cycles between mode command and clock gating; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sfraddr  input  7  SFR address.
REQ-006 SHALL have port sfrdatai  input  8  SFR write data.
REQ-007 SHALL have port sfrwe  input  1  SFR write strobe.
REQ-008 SHALL have port sfrdatao  output  8  PSCR read data, {WARM[3:0], 2'b00, MODE[1:0]}; MODE 0=run, 1=idle, 2=stop/warm-up.
REQ-009 SHALL have port wake_req  input  1  level wake-up request (pending enabled interrupt).
REQ-010 SHALL have port wdt_rst  input  1  watchdog reset request, one-cycle pulse.
REQ-011 SHALL have port clk_en_cpu  output  1  CPU clock gate enable.
REQ-012 SHALL have port clk_en_per  output  1  peripheral clock gate enable.
REQ-013 SHALL have port osc_en  output  1  oscillator enable.
REQ-014 SHALL have port busy  output  1  high whenever state is not RUN.

Function
REQ-015 SHALL implement states RUN, IDLE_ENTER, IDLE, STOP_ENTER, STOP, WARMUP.
REQ-016 PSCR write = sfrwe high and sfraddr==PSCR_ADDR, sampled on a rising edge; bit0 IDL, bit1 STP (command bits, not stored), bits[7:4] WARM (stored).
REQ-017 In RUN, a PSCR write with STP=1 SHALL go to STOP_ENTER; with STP=0, IDL=1 to IDLE_ENTER; STP SHALL win when both are set; WARM SHALL update on the same edge.
REQ-018 PSCR writes in any state other than RUN SHALL be ignored entirely, WARM included.
REQ-019 Drain: clock enables SHALL deassert on the DRAIN-th rising edge after the edge sampling the command (DRAIN=2: write at edge E0, gating visible after E2).
REQ-020 wake_req high during IDLE_ENTER or STOP_ENTER SHALL abort to RUN on the next edge with no gating.
REQ-021 IDLE: clk_en_cpu=0, clk_en_per=1, osc_en=1; wake_req sampled high SHALL return to RUN on that edge.
REQ-022 STOP: clk_en_cpu=0, clk_en_per=0, osc_en=0; wake_req sampled high at edge W0 SHALL enter WARMUP with osc_en=1 and counter loaded with N={WARM,4'h0}.
REQ-023 WARMUP: enables stay 0; counter decrements each edge; exit to RUN on the edge where counter==0, i.e. RUN at W0+N+1; wake_req deasserting SHALL NOT abort warm-up.
REQ-024 RUN: all three enables 1; outputs SHALL be registered, glitch-free.
REQ-025 wdt_rst SHALL force RUN on the next edge from any state, clear drain/warm counters, preserve WARM.
REQ-026 MODE SHALL read 0 in RUN, IDLE_ENTER, STOP_ENTER; 1 in IDLE; 2 in STOP and WARMUP.

Reset
REQ-027 rst SHALL set state RUN, clk_en_cpu=1, clk_en_per=1, osc_en=1, busy=0, WARM=4'h0, counters 0, sfrdatao=8'h00.
REQ-028 rst SHALL take priority over wdt_rst, wake_req and SFR writes, including mid-warm-up.

Structure
REQ-029 Package pwr_seq_pkg SHALL hold the state enumeration, MODE codes, PSCR bit positions and default PSCR_ADDR.
REQ-030 A single sub-module pwr_warm_cnt (8-bit loadable down-counter with zero flag) SHALL be used for both drain and warm-up counting.

Verification
REQ-031 Write 8'h01 to PSCR (DRAIN=2) -> clk_en_cpu 0 after 2nd edge, clk_en_per=1, MODE=1; wake_req -> RUN next edge.
REQ-032 Write 8'h22 (WARM=2) -> STOP after 2 edges, all enables 0; wake_req at W0 -> osc_en=1 at W0, RUN/clock enables 1 at W0+33.
REQ-033 Write 8'h03 -> STOP path taken (STP priority); wake_req during STOP_ENTER -> RUN next edge, enables never drop.
REQ-034 wdt_rst pulse mid-WARMUP (WARM=4'hF) -> RUN next edge, WARM still reads 4'hF.
REQ-035 rst asserted in STOP -> all enables 1, sfrdatao=8'h00 after one edge; PSCR write while in IDLE -> no state or WARM change.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power sequencer: state encoding,
// PSCR field positions, MODE read-back codes and the clock-enable decode.
package pwr_seq_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_IDLE_ENTER,
      ST_IDLE,
      ST_STOP_ENTER,
      ST_STOP,
      ST_WARMUP
   } pwr_state_t;

   localparam logic [1:0] MODE_RUN  = 2'd0;
   localparam logic [1:0] MODE_IDLE = 2'd1;
   localparam logic [1:0] MODE_STOP = 2'd2;

   localparam int PSCR_IDL     = 0;
   localparam int PSCR_STP     = 1;
   localparam int PSCR_WARM_LO = 4;
   localparam int PSCR_WARM_HI = 7;

   localparam logic [6:0] PSCR_ADDR_DEFAULT = 7'h0E;

   // {clk_en_cpu, clk_en_per, osc_en} for a given state; the ENTER states keep
   // everything running so in-flight work can drain.
   function automatic logic [2:0] pwr_enables(input pwr_state_t s);
      case (s)
         ST_IDLE:   return 3'b011;
         ST_STOP:   return 3'b000;
         ST_WARMUP: return 3'b001;
         default:   return 3'b111;
      endcase
   endfunction

   function automatic logic [1:0] pwr_mode(input pwr_state_t s);
      case (s)
         ST_IDLE:             return MODE_IDLE;
         ST_STOP, ST_WARMUP:  return MODE_STOP;
         default:             return MODE_RUN;
      endcase
   endfunction

endpackage

// File: rtl/pwr_warm_cnt.sv
// 8-bit loadable down-counter with zero flag; shared by the drain delay and
// the oscillator warm-up delay since the two never overlap.
module pwr_warm_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= 8'h00;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != 8'h00)
         cnt <= cnt - 8'h01;
   end

   assign zero = (cnt == 8'h00);

endmodule

// File: rtl/pwr_seq.sv
// Power sequencer: PSCR-commanded idle/stop entry with a drain delay, wake-up
// exit, and a programmable oscillator warm-up before clocks return.
module pwr_seq
   import pwr_seq_pkg::*;
#(
   parameter logic [6:0] PSCR_ADDR = PSCR_ADDR_DEFAULT,
   parameter int         DRAIN     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] sfraddr,
   input  logic [7:0] sfrdatai,
   input  logic       sfrwe,
   output logic [7:0] sfrdatao,
   input  logic       wake_req,
   input  logic       wdt_rst,
   output logic       clk_en_cpu,
   output logic       clk_en_per,
   output logic       osc_en,
   output logic       busy
);

   // Counter is loaded on the command edge, so DRAIN-1 more edges elapse
   // before the zero flag lets the ENTER state complete.
   localparam logic [7:0] DRAIN_LD = 8'(DRAIN - 1);

   pwr_state_t state, state_nxt;
   logic [3:0] warm;
   logic [1:0] mode;
   logic       pscr_wr, warm_wr;
   logic       cnt_load, cnt_dec, cnt_zero;
   logic [7:0] cnt_val;
   logic       unused_ok;

   assign pscr_wr   = sfrwe && (sfraddr == PSCR_ADDR);
   assign unused_ok = ^sfrdatai[3:2];

   always_comb begin
      state_nxt = state;
      warm_wr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = DRAIN_LD;
      cnt_dec   = 1'b0;
      if (wdt_rst) begin
         state_nxt = ST_RUN;
      end else begin
         unique case (state)
            ST_RUN: if (pscr_wr) begin
               warm_wr = 1'b1;
               if (sfrdatai[PSCR_STP]) begin
                  state_nxt = ST_STOP_ENTER;
                  cnt_load  = 1'b1;
               end else if (sfrdatai[PSCR_IDL]) begin
                  state_nxt = ST_IDLE_ENTER;
                  cnt_load  = 1'b1;
               end
            end
            ST_IDLE_ENTER, ST_STOP_ENTER: begin
               if (wake_req)
                  state_nxt = ST_RUN;
               else if (cnt_zero)
                  state_nxt = (state == ST_STOP_ENTER) ? ST_STOP : ST_IDLE;
               else
                  cnt_dec = 1'b1;
            end
            ST_IDLE: if (wake_req) state_nxt = ST_RUN;
            ST_STOP: if (wake_req) begin
               state_nxt = ST_WARMUP;
               cnt_load  = 1'b1;
               cnt_val   = {warm, 4'h0};
            end
            ST_WARMUP: begin
               if (cnt_zero)
                  state_nxt = ST_RUN;
               else
                  cnt_dec = 1'b1;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge
   // as the state register and come straight out of flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RUN;
         warm       <= 4'h0;
         mode       <= MODE_RUN;
         clk_en_cpu <= 1'b1;
         clk_en_per <= 1'b1;
         osc_en     <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (warm_wr)
            warm <= sfrdatai[PSCR_WARM_HI:PSCR_WARM_LO];
         mode <= pwr_mode(state_nxt);
         {clk_en_cpu, clk_en_per, osc_en} <= pwr_enables(state_nxt);
         busy <= (state_nxt != ST_RUN);
      end
   end

   assign sfrdatao = {warm, 2'b00, mode};

   pwr_warm_cnt u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (wdt_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

endmodule

// File: tb/tb_pwr_seq.sv
// Directed bench for pwr_seq: deadline-based reference model checked every
// cycle, plus hand-computed checkpoints for the documented scenarios.
module tb_pwr_seq;

   localparam int DRAIN = 2;
   localparam logic [6:0] PADDR = 7'h0E;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] sfraddr = 7'h00;
   logic [7:0] sfrdatai = 8'h00;
   logic       sfrwe = 1'b0;
   logic [7:0] sfrdatao;
   logic       wake_req = 1'b0;
   logic       wdt_rst = 1'b0;
   logic       clk_en_cpu, clk_en_per, osc_en, busy;

   int checks = 0;
   int failures = 0;

   pwr_seq #(.PSCR_ADDR(PADDR), .DRAIN(DRAIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .sfraddr    (sfraddr),
      .sfrdatai   (sfrdatai),
      .sfrwe      (sfrwe),
      .sfrdatao   (sfrdatao),
      .wake_req   (wake_req),
      .wdt_rst    (wdt_rst),
      .clk_en_cpu (clk_en_cpu),
      .clk_en_per (clk_en_per),
      .osc_en     (osc_en),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference model: phases with absolute-edge deadlines instead of counters.
   typedef enum {M_RUN, M_DRAIN_IDLE, M_DRAIN_STOP, M_IDLE, M_STOP, M_WARM} m_t;
   m_t         m = M_RUN;
   int         edge_no = 0;
   int         deadline = 0;
   logic [3:0] m_warm = 4'h0;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      edge_no <= edge_no + 1;
      if (rst) begin
         m       <= M_RUN;
         m_warm  <= 4'h0;
         m_valid <= 1'b1;
      end else if (wdt_rst) begin
         m <= M_RUN;
      end else begin
         case (m)
            M_RUN: if (sfrwe && sfraddr == PADDR) begin
               m_warm   <= sfrdatai[7:4];
               deadline <= edge_no + DRAIN;
               if (sfrdatai[1])      m <= M_DRAIN_STOP;
               else if (sfrdatai[0]) m <= M_DRAIN_IDLE;
            end
            M_DRAIN_IDLE, M_DRAIN_STOP: begin
               if (wake_req)               m <= M_RUN;
               else if (edge_no == deadline) m <= (m == M_DRAIN_STOP) ? M_STOP : M_IDLE;
            end
            M_IDLE: if (wake_req) m <= M_RUN;
            M_STOP: if (wake_req) begin
               m        <= M_WARM;
               deadline <= edge_no + 16 * int'(m_warm) + 1;
            end
            M_WARM: if (edge_no == deadline) m <= M_RUN;
            default: m <= M_RUN;
         endcase
      end
   end

   function automatic logic [11:0] model_out(input m_t s, input logic [3:0] w);
      logic [2:0] en;
      logic [1:0] md;
      en = (s == M_IDLE) ? 3'b011 : (s == M_STOP) ? 3'b000 : (s == M_WARM) ? 3'b001 : 3'b111;
      md = (s == M_IDLE) ? 2'd1 : (s == M_STOP || s == M_WARM) ? 2'd2 : 2'd0;
      return {en, (s != M_RUN), w, 2'b00, md};
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         logic [11:0] exp_v, act_v;
         exp_v = model_out(m, m_warm);
         act_v = {clk_en_cpu, clk_en_per, osc_en, busy, sfrdatao};
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_model edge=%0d got cpu/per/osc/busy/sfr=%b/%h required %b/%h",
                     edge_no, act_v[11:8], act_v[7:0], exp_v[11:8], exp_v[7:0]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pscr_wr(input logic [6:0] a, input logic [7:0] d);
      sfraddr = a; sfrdatai = d; sfrwe = 1'b1;
      step(1);
      sfrwe = 1'b0;
   endtask

   task automatic pulse_wake();
      wake_req = 1'b1; step(1); wake_req = 1'b0;
   endtask

   initial begin
      int k;
      step(3);
      rst = 1'b0;
      chk("reset_sfr", 32'(sfrdatao), 32'h00);
      chk("reset_en", 32'({clk_en_cpu, clk_en_per, osc_en, busy}), 32'b1110);

      // wrong address leaves PSCR alone
      pscr_wr(7'h0F, 8'hF1);
      chk("wrong_addr", 32'({sfrdatao, busy}), 32'({8'h00, 1'b0}));

      // idle entry with drain of 2 edges
      pscr_wr(PADDR, 8'h01);
      chk("idle_e0", 32'({clk_en_cpu, busy}), 32'b11);
      step(1);
      chk("idle_e1_cpu", 32'(clk_en_cpu), 32'd1);
      step(1);
      chk("idle_e2", 32'({clk_en_cpu, clk_en_per, osc_en, sfrdatao}), 32'({3'b011, 8'h01}));
      pscr_wr(PADDR, 8'hF2);
      chk("idle_write_ignored", 32'(sfrdatao), 32'h01);
      pulse_wake();
      chk("idle_wake", 32'({clk_en_cpu, busy, sfrdatao}), 32'({2'b10, 8'h00}));

      // stop with WARM=2: RUN at W0+33
      pscr_wr(PADDR, 8'h22);
      step(2);
      chk("stop_en", 32'({clk_en_cpu, clk_en_per, osc_en, sfrdatao}), 32'({3'b000, 8'h22}));
      pulse_wake();
      chk("warm_w0", 32'({clk_en_cpu, clk_en_per, osc_en, sfrdatao}), 32'({3'b001, 8'h22}));
      k = 0;
      while (!clk_en_cpu && k < 200) begin
         step(1);
         k++;
      end
      chk("warm_len", 32'(k), 32'd33);

      // both bits set: stop wins; WARM=0 gives one-edge warm-up
      pscr_wr(PADDR, 8'h03);
      step(2);
      chk("stp_priority", 32'({osc_en, sfrdatao}), 32'({1'b0, 8'h02}));
      pulse_wake();
      chk("warm0_w0", 32'({clk_en_cpu, osc_en}), 32'b01);
      step(1);
      chk("warm0_run", 32'({clk_en_cpu, busy}), 32'b10);

      // wake during drain aborts without gating
      pscr_wr(PADDR, 8'h03);
      pulse_wake();
      chk("abort", 32'({clk_en_cpu, clk_en_per, osc_en, busy}), 32'b1110);
      step(3);
      chk("abort_stays", 32'({clk_en_cpu, busy}), 32'b10);

      // watchdog mid warm-up keeps WARM
      pscr_wr(PADDR, 8'hF2);
      step(2);
      pulse_wake();
      step(10);
      chk("wdt_pre", 32'({busy, sfrdatao}), 32'({1'b1, 8'hF2}));
      wdt_rst = 1'b1; step(1); wdt_rst = 1'b0;
      chk("wdt_run", 32'({clk_en_cpu, busy, sfrdatao}), 32'({2'b10, 8'hF0}));

      // reset in STOP
      pscr_wr(PADDR, 8'h52);
      step(2);
      chk("stop52", 32'(sfrdatao), 32'h52);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("rst_stop", 32'({clk_en_cpu, clk_en_per, osc_en, sfrdatao}), 32'({3'b111, 8'h00}));

      // reset beats everything mid warm-up
      pscr_wr(PADDR, 8'hF2);
      step(2);
      pulse_wake();
      step(5);
      rst = 1'b1; wdt_rst = 1'b1; wake_req = 1'b1;
      sfraddr = PADDR; sfrdatai = 8'hF1; sfrwe = 1'b1;
      step(1);
      rst = 1'b0; wdt_rst = 1'b0; wake_req = 1'b0; sfrwe = 1'b0;
      chk("rst_priority", 32'({busy, sfrdatao}), 32'({1'b0, 8'h00}));

      // pseudo-random traffic, checked by the per-cycle model
      for (int i = 0; i < 600; i++) begin
         wake_req = ($urandom_range(0, 7) == 0);
         wdt_rst  = ($urandom_range(0, 79) == 0);
         sfrwe    = ($urandom_range(0, 5) == 0);
         sfraddr  = ($urandom_range(0, 3) == 0) ? 7'h0D : PADDR;
         sfrdatai = 8'($urandom_range(0, 255)) & 8'h3F | ($urandom_range(0, 1) != 0 ? 8'h10 : 8'h00);
         step(1);
      end
      wake_req = 1'b0; wdt_rst = 1'b0; sfrwe = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
